// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC fetch unit.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    localparam int INSTR_BYTES   = 4;
    localparam int DEF_ADDR_W    = 64;
    localparam int DEF_INSTR_W   = 32;
    localparam int DEF_BUF_DEPTH = 2;

    // True when a memory request is still in flight after the current cycle.
    function automatic logic outstanding_after(input fetch_state_e st,
                                               input logic req_fire,
                                               input logic rsp_valid);
        logic busy;
        case (st)
            S_REQ:   busy = req_fire;
            S_WAIT:  busy = !rsp_valid;
            S_DROP:  busy = !rsp_valid;
            default: busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_checker.sv
// Protocol checks for the fetch unit's memory interface.
module pc_fetch_unit_checker
    import pc_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input logic              clk,
    input logic              rst,
    input fetch_state_e      state,
    input logic              redirect,
    input logic              req_valid,
    input logic              req_ready,
    input logic [ADDR_W-1:0] req_addr,
    input logic              rsp_valid
);

    // A response is only legal while a request is in flight.
    a_rsp_outstanding: assert property (@(posedge clk) disable iff (rst)
        rsp_valid |-> (state != S_REQ));

    // A stalled request keeps its address unless redirected.
    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (req_valid && !req_ready && !redirect) |=> $stable(req_addr));

endmodule

// File: rtl/pc_fetch_unit_fetch_buffer.sv
// Small power-of-two FIFO holding fetched {instruction, pc} entries for decode.
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && (count_q != DEPTH_C);
    assign do_pop_s  = pop && (count_q != {(PW+1){1'b0}});
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Next storage, pointers and occupancy; flush empties the queue and wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {(PW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + (PW+1)'(do_push_s) - (PW+1)'(do_pop_s);
        end
    end

    // Buffer state registers; entries clear on reset so the head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {(PW+1){1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: owns FetchPC, issues one-at-a-time word fetches and queues results for decode.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = DEF_BUF_DEPTH,
    parameter int                INSTR_W   = DEF_INSTR_W
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  RedirectPC,
    output logic               IMemReqValid,
    input  logic               IMemReqReady,
    output logic [ADDR_W-1:0]  IMemReqAddr,
    input  logic               IMemRspValid,
    input  logic [INSTR_W-1:0] IMemRspData,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC
);

    localparam int                CW         = $clog2(BUF_DEPTH) + 1;
    localparam int                EW         = INSTR_W + ADDR_W;
    localparam logic [CW-1:0]     DEPTH_C    = CW'(BUF_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_C     = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              req_valid_q, req_valid_d;
    logic [CW-1:0]     count_s;
    logic [CW-1:0]     count_nxt_s;
    logic [EW-1:0]     head_s;
    logic              req_fire_s;
    logic              push_s;
    logic              pop_s;
    logic              instr_valid_s;

    assign instr_valid_s = (count_s != {CW{1'b0}});
    assign req_fire_s    = req_valid_q && IMemReqReady;
    // Redirect discards the returning word and the decode pop of this cycle.
    assign push_s        = (state_q == S_WAIT) && IMemRspValid && !Redirect;
    assign pop_s         = instr_valid_s && InstrReady && !Redirect;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (EW)
    ) u_buf (
        .clk       (CLK),
        .rst       (Reset),
        .flush     (Redirect),
        .push      (push_s),
        .push_data ({IMemRspData, fetch_pc_q - STEP_C}),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (count_s)
    );

    // Mirror of the buffer occupancy one cycle ahead, used to pre-compute request valid.
    always_comb begin
        count_nxt_s = count_s;
        if (Redirect) begin
            count_nxt_s = {CW{1'b0}};
        end else begin
            count_nxt_s = count_s + CW'(push_s) - CW'(pop_s);
        end
    end

    // FSM, FetchPC and request-valid registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

    // Next-state logic; a redirect with a request still in flight must drop its response.
    always_comb begin
        state_d = state_q;
        if (Redirect) begin
            if (outstanding_after(state_q, req_fire_s, IMemRspValid)) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end else begin
            case (state_q)
                S_REQ:   state_d = req_fire_s   ? S_WAIT : S_REQ;
                S_WAIT:  state_d = IMemRspValid ? S_REQ  : S_WAIT;
                S_DROP:  state_d = IMemRspValid ? S_REQ  : S_DROP;
                default: state_d = S_REQ;
            endcase
        end
    end

    // FetchPC update: redirect target (word aligned) or advance on an accepted request.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (Redirect) begin
            fetch_pc_d = RedirectPC & ALIGN_MASK;
        end else if (req_fire_s) begin
            fetch_pc_d = fetch_pc_q + STEP_C;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // Output logic: request only from S_REQ and only while the buffer has room next cycle.
    always_comb begin
        req_valid_d = 1'b0;
        if ((state_d == S_REQ) && (count_nxt_s < DEPTH_C)) begin
            req_valid_d = 1'b1;
        end else begin
            req_valid_d = 1'b0;
        end
    end

    assign IMemReqValid = req_valid_q;
    assign IMemReqAddr  = fetch_pc_q;
    assign InstrValid   = instr_valid_s;
    assign Instr        = head_s[EW-1:ADDR_W];
    assign InstrPC      = head_s[ADDR_W-1:0];

    pc_fetch_unit_checker #(
        .ADDR_W (ADDR_W)
    ) u_chk (
        .clk       (CLK),
        .rst       (Reset),
        .state     (state_q),
        .redirect  (Redirect),
        .req_valid (req_valid_q),
        .req_ready (IMemReqReady),
        .req_addr  (fetch_pc_q),
        .rsp_valid (IMemRspValid)
    );

endmodule
